// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: buffers pre-classified instruction words
// and hands them to ID in order under a valid/ack handshake.

package if_id_queue_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] predict_address;
        logic        predict_taken;
    } branchpredict_sbe;

    typedef struct packed {
        logic [63:0]      address;
        logic [31:0]      instruction;
        branchpredict_sbe branch_predict;
        logic             is_compressed;
        logic             is_illegal;
    } fetch_entry;

endpackage

module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [63:0]                in_addr_i,
    input  logic [31:0]                in_instr_i,
    input  branchpredict_sbe           in_bp_i,
    output fetch_entry                 fetch_entry_o,
    output logic                       fetch_valid_o,
    input  logic                       fetch_ack_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_entry      mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop;
    fetch_entry      new_entry;

    assign in_ready_o    = (count_q != FULL);
    assign fetch_valid_o = (count_q != '0);
    assign count_o       = count_q;
    assign fetch_entry_o = fetch_valid_o ? mem_q[rd_ptr_q] : '0;

    assign push = in_valid_i && in_ready_o && !flush_i;
    assign pop  = fetch_valid_o && fetch_ack_i && !flush_i;

    always_comb begin
        new_entry                = '0;
        new_entry.address        = in_addr_i;
        new_entry.instruction    = in_instr_i;
        new_entry.branch_predict = in_bp_i;
        new_entry.is_compressed  = (in_instr_i[1:0] != 2'b11);
        new_entry.is_illegal     = (in_instr_i[15:0] == 16'h0000) ||
                                   (in_instr_i == 32'hFFFF_FFFF);
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Slot data is not reset; the zero-when-empty output mux hides stale words.
    always_ff @(posedge clk_i) begin
        if (rst_ni && push) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

endmodule
